// File: rtl/timer_slot_scheduler.sv
// timer_slot_scheduler
//
// Purpose: gives one shared 1-second timer to NREQ requesters in round-robin
// order. The current owner loads its seconds count when it is granted. Each
// timeout pulse then counts it down by one. When the count reaches zero the
// owner receives a one-cycle done pulse. Only one countdown runs at a time.
//
// Ports:
//   clk          system clock; all state changes on its rising edge
//   rst          asynchronous, active-low reset
//   req          level request per requester; held until done, or dropped to abort
//   secs         packed seconds counts, requester i at [i*CW +: CW]; sampled at grant only
//   timeout      one-cycle pulse per elapsed second from the shared timer
//   Timer_Enable enable to the shared timer
//   grant        one-hot owner of the timer; all zero when idle
//   done         one-cycle completion pulse to the owner
//   busy         high whenever the scheduler is not idle
//   remaining    seconds left in the active countdown
//
// State table
//   state | meaning
//   IDLE  | no owner; arbitrate among pending requests, ignore timeout
//   RUN   | timer enabled; count timeout pulses down for the owner
//   DONE  | one cycle; done and grant asserted, then release the timer

module timer_slot_scheduler #(
    parameter int NREQ = 4,
    parameter int CW   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*CW-1:0] secs,
    input  logic               timeout,
    output logic               Timer_Enable,
    output logic [NREQ-1:0]    grant,
    output logic [NREQ-1:0]    done,
    output logic               busy,
    output logic [CW-1:0]      remaining
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   idx_q, idx_d;
    logic [CW-1:0]   rem_q, rem_d;
    logic            te_q, te_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            busy_q, busy_d;

    // Round-robin search. It starts just after the last owner, so that
    // owner has the lowest priority in the next arbitration.
    logic            win_found;
    logic [PW-1:0]   win_idx;
    logic [PW-1:0]   cand;
    logic [CW-1:0]   win_secs;
    logic [NREQ-1:0] win_onehot;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = PW'((int'(ptr_q) + k) % NREQ);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
        win_secs   = secs[win_idx*CW +: CW];
        win_onehot = NREQ'(1) << win_idx;
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        rem_d   = rem_q;
        te_d    = te_q;
        grant_d = grant_q;
        done_d  = '0;

        case (state_q)
            IDLE: begin
                if (win_found) begin
                    idx_d   = win_idx;
                    rem_d   = win_secs;
                    grant_d = win_onehot;
                    if (win_secs != '0) begin
                        state_d = RUN;
                        te_d    = 1'b1;
                    end else begin
                        // A zero-second request completes without starting the timer.
                        state_d = DONE;
                        done_d  = win_onehot;
                    end
                end
            end

            RUN: begin
                // A withdrawn request takes priority over a timeout in the same cycle.
                if (!req[idx_q]) begin
                    state_d = IDLE;
                    te_d    = 1'b0;
                    grant_d = '0;
                    rem_d   = '0;
                    ptr_d   = idx_q;
                end else if (timeout) begin
                    if (rem_q <= CW'(1)) begin
                        state_d = DONE;
                        te_d    = 1'b0;
                        rem_d   = '0;
                        done_d  = NREQ'(1) << idx_q;
                    end else begin
                        rem_d = rem_q - CW'(1);
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
                grant_d = '0;
                ptr_d   = idx_q;
            end

            default: begin
                state_d = IDLE;
                te_d    = 1'b0;
                grant_d = '0;
                rem_d   = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= PW'(NREQ - 1);
            idx_q   <= '0;
            rem_q   <= '0;
            te_q    <= 1'b0;
            grant_q <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            rem_q   <= rem_d;
            te_q    <= te_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign Timer_Enable = te_q;
    assign grant        = grant_q;
    assign done         = done_q;
    assign busy         = busy_q;
    assign remaining    = rem_q;

endmodule
